fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter_pkg.sv | 13 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 142 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;

  // Width of the accepted-write counter.
  localparam int unsigned WR_CNT_W = 16;

  // Burst lock state (only used when FIFO_ARB_BURST_EN is defined).
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority search: first set bit of valid_i starting at ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] pos;

  // Walk N positions from ptr_i and keep the first valid one.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = IW'((32'(ptr_i) + k) % N);
      if (!any_o && valid_i[pos]) begin
        any_o      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter feeding a single FIFO write port.
// Optional burst locking is enabled with the FIFO_ARB_BURST_EN macro.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [WR_CNT_W-1:0]           wr_count
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || BURST_LEN < 1) begin : g_bad_cfg
    $error("fifo_wr_arbiter: illegal NUM_REQ or BURST_LEN");
  end

  logic [IDX_W-1:0]      ptr_q;
  logic [IDX_W-1:0]      grant_q;
  logic [WR_CNT_W-1:0]   wr_cnt_q;
  logic [NUM_REQ-1:0]    valid_eff;
  logic [IDX_W-1:0]      pick_ptr;
  logic [NUM_REQ-1:0]    pick_gnt;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  wr_c;
  logic [DATA_WIDTH-1:0] wdata_c;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned BCNT_W = $clog2(BURST_LEN + 1);

  arb_state_e        state_q;
  logic [IDX_W-1:0]  held_q;
  logic [BCNT_W-1:0] bcnt_q;

  // While locked only the held requester is eligible.
  always_comb begin
    valid_eff = req_valid;
    pick_ptr  = ptr_q;
    if (state_q == LOCK) begin
      valid_eff = req_valid & (NUM_REQ'(1) << held_q);
      pick_ptr  = held_q;
    end
  end
`else
  assign valid_eff = req_valid;
  assign pick_ptr  = ptr_q;
`endif

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_pick (
    .valid_i (valid_eff),
    .ptr_i   (pick_ptr),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Zero-latency handshake; reset forces everything quiet immediately.
  always_comb begin
    wr_c    = pick_any && !fifo_full && !rst;
    wdata_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (wr_c && pick_gnt[i]) wdata_c = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign req_ready       = wr_c ? pick_gnt : '0;
  assign fifo_write_en   = wr_c;
  assign fifo_write_data = wdata_c;
  assign grant_id        = grant_q;
  assign wr_count        = wr_cnt_q;

  // Grant bookkeeping, pointer rotation and burst lock tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      grant_q  <= '0;
      wr_cnt_q <= '0;
`ifdef FIFO_ARB_BURST_EN
      state_q  <= IDLE;
      held_q   <= '0;
      bcnt_q   <= '0;
`endif
    end else begin
      if (wr_c) begin
        grant_q  <= pick_idx;
        wr_cnt_q <= wr_cnt_q + 1'b1;
      end
`ifdef FIFO_ARB_BURST_EN
      case (state_q)
        IDLE: begin
          if (wr_c) begin
            if (BURST_LEN <= 1) begin
              ptr_q <= ptr_inc(pick_idx);
            end else begin
              state_q <= LOCK;
              held_q  <= pick_idx;
              bcnt_q  <= BCNT_W'(1);
            end
          end
        end
        LOCK: begin
          if (!req_valid[held_q]) begin
            state_q <= IDLE;
            ptr_q   <= ptr_inc(held_q);
            bcnt_q  <= '0;
          end else if (wr_c) begin
            if (32'(bcnt_q) + 32'd1 >= BURST_LEN) begin
              state_q <= IDLE;
              ptr_q   <= ptr_inc(held_q);
              bcnt_q  <= '0;
            end else begin
              bcnt_q  <= bcnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
`else
      if (wr_c) ptr_q <= ptr_inc(pick_idx);
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized self-checking bench for fifo_wr_arbiter with a behavioural model.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int BL = 4;
`ifdef FIFO_ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_write_en;
  logic [DW-1:0]    fifo_write_data;
  logic [1:0]       grant_id;
  logic [15:0]      wr_count;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .fifo_full       (fifo_full),
    .fifo_write_en   (fifo_write_en),
    .fifo_write_data (fifo_write_data),
    .grant_id        (grant_id),
    .wr_count        (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state: rotation pointer, last grant, write count, burst lock.
  int m_ptr, m_last, m_cnt, m_held, m_bc;
  bit m_lock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0; m_last = 0; m_cnt = 0; m_held = 0; m_bc = 0; m_lock = 0;
  endfunction

  function automatic int model_winner(input logic [NR-1:0] v);
    if (m_lock) return v[m_held] ? m_held : -1;
    for (int k = 0; k < NR; k++) begin
      if (v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic void model_update(input logic [NR-1:0] v, input int w);
    if (w >= 0) begin
      m_cnt  = (m_cnt + 1) % 65536;
      m_last = w;
    end
    if (BURST) begin
      if (!m_lock) begin
        if (w >= 0) begin
          if (BL > 1) begin m_lock = 1; m_held = w; m_bc = 1; end
          else m_ptr = (w + 1) % NR;
        end
      end else if (!v[m_held]) begin
        m_lock = 0; m_ptr = (m_held + 1) % NR;
      end else if (w >= 0) begin
        m_bc++;
        if (m_bc == BL) begin m_lock = 0; m_ptr = (m_held + 1) % NR; end
      end
    end else if (w >= 0) begin
      m_ptr = (w + 1) % NR;
    end
  endfunction

  // One cycle: drive at negedge, check before posedge, advance model at posedge.
  // exp_g >= -1 adds an independent check of the expected winner (-1 = none).
  task automatic step(input logic [NR-1:0] v, input logic f, input int exp_g);
    int w;
    logic [DW-1:0] exp_d;
    req_valid = v;
    fifo_full = f;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom;
    #1;
    w = f ? -1 : model_winner(v);
    exp_d = '0;
    if (w >= 0) exp_d = req_data[w*DW +: DW];
    chk("ready", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
    chk("wen", 32'(fifo_write_en), (w >= 0) ? 32'd1 : 32'd0);
    chk("wdata", fifo_write_data, exp_d);
    chk("grant_id", 32'(grant_id), 32'(m_last));
    chk("wr_count", 32'(wr_count), 32'(m_cnt));
    chk("wen_while_full", 32'(fifo_write_en & fifo_full), 32'd0);
    chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    if (exp_g >= -1)
      chk("seq", 32'(req_ready), (exp_g < 0) ? 32'd0 : (32'd1 << exp_g));
    @(posedge clk);
    model_update(v, w);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = NR'($urandom);
    fifo_full = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wen", 32'(fifo_write_en), 32'd0);
    chk("rst_wdata", fifo_write_data, 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_wcnt", 32'(wr_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int g;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    fifo_full = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // All requesters valid for 8 cycles.
    for (int k = 0; k < 8; k++) step(4'b1111, 1'b0, BURST ? k / 4 : k % 4);
    chk("wr_count_8", 32'(wr_count), 32'd8);

    // Single requester, then FIFO full stall.
    do_reset();
    for (int k = 0; k < 3; k++) step(4'b0100, 1'b0, 2);
    for (int k = 0; k < 2; k++) step(4'b0100, 1'b1, -1);
    chk("wr_count_3", 32'(wr_count), 32'd3);

    // Wrap from requester 3 back to 0.
    do_reset();
    step(4'b1000, 1'b0, 3);
    for (int k = 0; k < 4; k++) begin
      if (BURST) g = (k < 3) ? 3 : 0;
      else       g = (k % 2 == 0) ? 0 : 3;
      step(4'b1001, 1'b0, g);
    end

    // Two requesters held: burst blocks vs alternation.
    do_reset();
    for (int k = 0; k < 8; k++) step(4'b0011, 1'b0, BURST ? k / 4 : k % 2);

    // Reset during the second beat aborts it asynchronously.
    do_reset();
    step(4'b0011, 1'b0, 0);
    req_valid = 4'b0011;
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_wen", 32'(fifo_write_en), 32'd0);
    chk("mid_rst_wdata", fifo_write_data, 32'd0);
    chk("mid_rst_gid", 32'(grant_id), 32'd0);
    chk("mid_rst_wcnt", 32'(wr_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(4'b0110, 1'b0, 1);

    // Randomized traffic with occasional full stalls and resets.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      else step(NR'($urandom), ($urandom_range(0, 3) == 0), -2);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
